// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  localparam int unsigned WAIT_CNT_W = 4;

  // RISC-V funct3 access sizes
  typedef enum logic [2:0] {
    SZ_B  = 3'b000,
    SZ_H  = 3'b001,
    SZ_W  = 3'b010,
    SZ_BU = 3'b100,
    SZ_HU = 3'b101
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Latched request payload; size kept raw so illegal encodings survive to the fault check
  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } dmem_req_t;

  function automatic logic size_legal(input logic [2:0] size, input logic write);
    case (size)
      SZ_B, SZ_H, SZ_W: size_legal = 1'b1;
      SZ_BU, SZ_HU:     size_legal = !write;
      default:          size_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// Word-organised data storage: byte-lane synchronous write, combinational read.
module dmem_bank #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [3:0]       we_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we_i[b]) mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
    end
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder with fixed wait states and a held response handshake.
// Define DMEM_ALIGN_CHECK_EN to fault misaligned halfword/word accesses instead of aligning down.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam bit HAS_WAIT = (WAIT_CYCLES != 0);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_CYCLES - 1);

  state_e                state_q, state_d;
  dmem_req_t             req_q, req_d, req_in, acc;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic                  req_ready_q, req_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [31:0]           rsp_rdata_q, rsp_rdata_d;

  logic                  accept, rsp_hs, commit;
  logic                  oob, misalign, fault;
  logic [IDX_W-1:0]      bank_idx;
  logic [3:0]            bank_we, lane_be;
  logic [31:0]           bank_wdata, bank_rdata, load_data;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;

  assign req_in    = '{write: req_write, addr: req_addr, size: req_size, wdata: req_wdata};
  assign accept    = (state_q == IDLE) && req_valid && req_ready_q;
  assign rsp_hs    = rsp_valid_q && rsp_ready;

  // With no wait states the commit happens on the accept edge, straight from the port
  assign acc       = (state_q == IDLE) ? req_in : req_q;
  assign bank_idx  = acc.addr[IDX_W+1:2];
  assign oob       = (acc.addr[31:2] >> IDX_W) != 30'd0;

`ifdef DMEM_ALIGN_CHECK_EN
  always_comb begin
    misalign = 1'b0;
    case (acc.size)
      SZ_H, SZ_HU: misalign = acc.addr[0];
      SZ_W:        misalign = (acc.addr[1:0] != 2'b00);
      default:     misalign = 1'b0;
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

  assign fault = !size_legal(acc.size, acc.write) || oob || misalign;

  // Store lane steering; low address bits below the access size are dropped
  always_comb begin
    lane_be    = 4'b0000;
    bank_wdata = acc.wdata;
    case (acc.size)
      SZ_B: begin
        lane_be    = 4'b0001 << acc.addr[1:0];
        bank_wdata = {4{acc.wdata[7:0]}};
      end
      SZ_H: begin
        lane_be    = acc.addr[1] ? 4'b1100 : 4'b0011;
        bank_wdata = {2{acc.wdata[15:0]}};
      end
      SZ_W:    lane_be = 4'b1111;
      default: lane_be = 4'b0000;
    endcase
  end

  // Load lane selection and extension
  always_comb begin
    case (acc.addr[1:0])
      2'd0:    byte_sel = bank_rdata[7:0];
      2'd1:    byte_sel = bank_rdata[15:8];
      2'd2:    byte_sel = bank_rdata[23:16];
      default: byte_sel = bank_rdata[31:24];
    endcase
    half_sel = acc.addr[1] ? bank_rdata[31:16] : bank_rdata[15:0];
    case (acc.size)
      SZ_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      SZ_BU:   load_data = {24'd0, byte_sel};
      SZ_H:    load_data = {{16{half_sel[15]}}, half_sel};
      SZ_HU:   load_data = {16'd0, half_sel};
      SZ_W:    load_data = bank_rdata;
      default: load_data = 32'd0;
    endcase
  end

  dmem_bank #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_bank (
    .clk    (clk),
    .idx_i  (bank_idx),
    .we_i   (bank_we),
    .wdata_i(bank_wdata),
    .rdata_o(bank_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = HAS_WAIT ? WAIT : RESP;
      WAIT:    if (cnt_q == '0) state_d = RESP;
      RESP:    if (rsp_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // rsp_valid is registered off the RESP state, so it rises one cycle after commit
  always_comb begin
    req_d       = req_q;
    cnt_d       = cnt_q;
    commit      = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    req_ready_d = (state_d == IDLE);
    bank_we     = 4'b0000;
    case (state_q)
      IDLE: begin
        if (accept) begin
          req_d  = req_in;
          cnt_d  = HAS_WAIT ? WAIT_LOAD : '0;
          commit = !HAS_WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) commit = 1'b1;
        else             cnt_d  = cnt_q - 1'b1;
      end
      RESP:    rsp_valid_d = !rsp_hs;
      default: rsp_valid_d = 1'b0;
    endcase
    if (commit) begin
      rsp_err_d   = fault;
      rsp_rdata_d = (fault || acc.write) ? 32'd0 : load_data;
      if (acc.write && !fault && !reset) bank_we = lane_be;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_q       <= '0;
      cnt_q       <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'd0;
    end else begin
      req_q       <= req_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a byte-array reference model.
module tb_dmem_responder;

  localparam int DEPTH = 256;
  localparam int WAITC = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_size;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  int tests = 0;
  int fails = 0;

  logic [7:0] mem_m [DEPTH*4];

  dmem_responder #(
    .DEPTH_WORDS(DEPTH),
    .WAIT_CYCLES(WAITC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_size (req_size),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: an access touches nb bytes starting at the size-aligned address
  task automatic model(input logic w, input logic [31:0] a, input logic [2:0] sz,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er);
    int nb;
    int base;
    logic [31:0] v;
    rd = 32'd0;
    er = 1'b0;
    case (sz)
      3'd0, 3'd4: nb = 1;
      3'd1, 3'd5: nb = 2;
      3'd2:       nb = 4;
      default:    nb = 0;
    endcase
    if (nb == 0 || (w && sz >= 3'd4) || (a >> 2) >= 32'(DEPTH)) begin
      er = 1'b1;
      return;
    end
`ifdef DMEM_ALIGN_CHECK_EN
    if ((int'(a) % nb) != 0) begin
      er = 1'b1;
      return;
    end
`endif
    base = int'(a) - (int'(a) % nb);
    if (w) begin
      for (int i = 0; i < nb; i++) mem_m[base+i] = wd[8*i +: 8];
    end else begin
      v = 32'd0;
      for (int i = 0; i < nb; i++) v = v | (32'(mem_m[base+i]) << (8*i));
      if (sz == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
      if (sz == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
      rd = v;
    end
  endtask

  task automatic do_txn(input logic w, input logic [31:0] a, input logic [2:0] sz,
                        input logic [31:0] wd, input int hold,
                        input logic [31:0] exp_rd, input logic exp_er, input string tag);
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_size  = sz;
    req_wdata = wd;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, ":req_ready"}, 32'(req_ready), 32'd1);
    n = 0;
    do begin
      @(negedge clk);
      req_valid = 1'b0;
      n++;
    end while (!rsp_valid && n < 40);
    check({tag, ":latency"}, 32'(n), 32'(2 + WAITC));
    check({tag, ":rdata"}, rsp_rdata, exp_rd);
    check({tag, ":err"}, 32'(rsp_err), 32'(exp_er));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, ":hold_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, ":hold_rdata"}, rsp_rdata, exp_rd);
      check({tag, ":hold_ready"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, ":valid_drop"}, 32'(rsp_valid), 32'd0);
    check({tag, ":ready_back"}, 32'(req_ready), 32'd1);
  endtask

  task automatic run(input logic w, input logic [31:0] a, input logic [2:0] sz,
                     input logic [31:0] wd, input int hold, input string tag);
    logic [31:0] r;
    logic e;
    model(w, a, sz, wd, r, e);
    do_txn(w, a, sz, wd, hold, r, e, tag);
  endtask

  // Directed access against hand-derived values; model still tracks memory
  task automatic drun(input logic w, input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] wd, input int hold,
                      input logic [31:0] exp_rd, input logic exp_er, input string tag);
    logic [31:0] r;
    logic e;
    model(w, a, sz, wd, r, e);
    do_txn(w, a, sz, wd, hold, exp_rd, exp_er, tag);
  endtask

  initial begin
    logic        w;
    logic [31:0] a;
    logic [2:0]  sz;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 32'd0;
    req_size  = 3'd0;
    req_wdata = 32'd0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst:req_ready", 32'(req_ready), 32'd0);
    check("rst:rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst:rsp_err", 32'(rsp_err), 32'd0);
    check("rst:rsp_rdata", rsp_rdata, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rst:ready_after", 32'(req_ready), 32'd1);

    for (int i = 0; i < DEPTH; i++) run(1'b1, 32'(i*4), 3'd2, $urandom, 0, "fill");

    drun(1'b1, 32'h10, 3'd2, 32'hDEAD_BEEF, 0, 32'd0, 1'b0, "sw10");
    drun(1'b0, 32'h10, 3'd2, 32'd0, 0, 32'hDEAD_BEEF, 1'b0, "lw10");
    drun(1'b1, 32'h13, 3'd0, 32'h0000_0080, 0, 32'd0, 1'b0, "sb13");
    drun(1'b0, 32'h13, 3'd0, 32'd0, 0, 32'hFFFF_FF80, 1'b0, "lb13");
    drun(1'b0, 32'h13, 3'd4, 32'd0, 0, 32'h0000_0080, 1'b0, "lbu13");
    drun(1'b0, 32'h10, 3'd2, 32'd0, 0, 32'h80AD_BEEF, 1'b0, "lw10b");
    drun(1'b1, 32'h22, 3'd1, 32'h0000_8001, 0, 32'd0, 1'b0, "sh22");
    drun(1'b0, 32'h22, 3'd1, 32'd0, 0, 32'hFFFF_8001, 1'b0, "lh22");
    drun(1'b0, 32'h22, 3'd5, 32'd0, 0, 32'h0000_8001, 1'b0, "lhu22");
    drun(1'b0, 32'(DEPTH*4), 3'd2, 32'd0, 0, 32'd0, 1'b1, "lw_oob");
    drun(1'b1, 32'h10, 3'd4, 32'h1234_5678, 0, 32'd0, 1'b1, "sbu_ill");
    drun(1'b0, 32'h10, 3'd2, 32'd0, 0, 32'h80AD_BEEF, 1'b0, "lw10c");
    drun(1'b0, 32'h10, 3'd3, 32'd0, 0, 32'd0, 1'b1, "sz011");
    drun(1'b1, 32'h30, 3'd2, 32'hCAFE_F00D, 0, 32'd0, 1'b0, "sw30");
`ifdef DMEM_ALIGN_CHECK_EN
    drun(1'b1, 32'h31, 3'd2, 32'h1234_5678, 0, 32'd0, 1'b1, "sw31");
    drun(1'b0, 32'h30, 3'd2, 32'd0, 0, 32'hCAFE_F00D, 1'b0, "lw30");
`else
    drun(1'b1, 32'h31, 3'd2, 32'h1234_5678, 0, 32'd0, 1'b0, "sw31");
    drun(1'b0, 32'h30, 3'd2, 32'd0, 0, 32'h1234_5678, 1'b0, "lw30");
`endif
    drun(1'b0, 32'h10, 3'd2, 32'd0, 5, 32'h80AD_BEEF, 1'b0, "hold5");

    // Reset while a store sits in WAIT: the store must be dropped
    drun(1'b1, 32'h40, 3'd2, 32'h1111_1111, 0, 32'd0, 1'b0, "sw40");
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h40;
    req_size  = 3'd2;
    req_wdata = 32'h2222_2222;
    check("rstw:ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    reset     = 1'b1;
    @(negedge clk);
    check("rstw:rsp_valid", 32'(rsp_valid), 32'd0);
    check("rstw:req_ready", 32'(req_ready), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rstw:ready_after", 32'(req_ready), 32'd1);
    check("rstw:valid_after", 32'(rsp_valid), 32'd0);
    drun(1'b0, 32'h40, 3'd2, 32'd0, 0, 32'h1111_1111, 1'b0, "lw40");

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0) a = 32'(DEPTH*4) + ($urandom & 32'h7FFF_FFFF) % 32'h7000_0000;
      else                           a = 32'($urandom_range(0, DEPTH*4 - 1));
      sz = 3'($urandom_range(0, 7));
      w  = 1'($urandom_range(0, 1));
      run(w, a, sz, $urandom, int'($urandom_range(0, 2)), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
